// File: rtl/shot_clock_pkg.sv
// rtl/shot_clock_pkg.sv - shared types and constants for the shot-clock control stage
// Purpose: FSM state enum and BCD reload values shared by the shot-clock blocks.
package shot_clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam logic [3:0] RELOAD24_TENS = 4'd2;
  localparam logic [3:0] RELOAD24_ONES = 4'd4;
  localparam logic [3:0] RELOAD14_TENS = 4'd1;
  localparam logic [3:0] RELOAD14_ONES = 4'd4;

endpackage

// File: rtl/shot_clock_tick_gen.sv
// rtl/shot_clock_tick_gen.sv - prescaler producing a one-cycle tick every TICK_DIV advancing cycles
// Purpose: free-running divider that only counts while adv is high.
// Ports:
//   clk   in  system clock, rising edge
//   reset in  synchronous active-high reset, clears the count
//   clr   in  clears the count (a reload discards any partial second)
//   adv   in  count enable; the count holds while low
//   tick  out high in the cycle the count sits at TICK_DIV-1 while advancing
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic adv,
  output logic tick
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] r_cnt;
  logic         w_tick;

  assign w_tick = adv && (r_cnt == LAST);
  assign tick   = w_tick;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= '0;
    end else if (adv) begin
      r_cnt <= w_tick ? '0 : r_cnt + ONE;
    end
  end

endmodule

// File: rtl/shot_clock_ctrl.sv
// rtl/shot_clock_ctrl.sv - 24/14-second BCD shot clock with alarm and display load strobe
// Purpose: FSM, BCD down-counter, alarm timer and display strobe around a tick prescaler.
// Ports:
//   clk      in  system clock, rising edge
//   reset    in  synchronous active-high reset
//   start    in  pulse: begin/resume counting (IDLE, PAUSE)
//   pause    in  pulse: freeze counting (RUN)
//   reload   in  pulse: load 24, go IDLE (beats reload14)
//   reload14 in  pulse: load 14, go IDLE
//   tens     out BCD tens digit
//   ones     out BCD ones digit
//   disp_en  out one-cycle load strobe, the cycle after the digits change
//   running  out high while in RUN
//   alarm    out high for ALARM_TICKS seconds after reaching 00
module shot_clock_ctrl
  import shot_clock_pkg::*;
#(
  parameter int TICK_DIV    = 50_000_000,
  parameter int ALARM_TICKS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       reload,
  input  logic       reload14,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       disp_en,
  output logic       running,
  output logic       alarm
);

  localparam int AW = $clog2(ALARM_TICKS + 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);
  localparam logic [AW-1:0] ALARM_ONE  = AW'(1);

  state_t          r_state, w_state_nx;
  logic [3:0]      r_tens, r_ones, w_tens_nx, w_ones_nx;
  logic            r_alarm, w_alarm_nx;
  logic [AW-1:0]   r_alarm_cnt, w_alarm_cnt_nx;
  logic            r_upd, w_upd;
  logic            r_disp_en;
  logic            r_running;
  logic            w_tick;
  logic            w_adv;
  logic            w_clr;

  assign w_adv = (r_state == ST_RUN) || (r_state == ST_EXPIRED);
  assign w_clr = reload || reload14;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clr  (w_clr),
    .adv  (w_adv),
    .tick (w_tick)
  );

  always_comb begin
    w_state_nx     = r_state;
    w_tens_nx      = r_tens;
    w_ones_nx      = r_ones;
    w_alarm_nx     = r_alarm;
    w_alarm_cnt_nx = r_alarm_cnt;
    w_upd          = 1'b0;
    if (reload) begin
      // Reload overrides any coincident tick, so no alarm can be raised this cycle.
      w_state_nx = ST_IDLE;
      w_tens_nx  = RELOAD24_TENS;
      w_ones_nx  = RELOAD24_ONES;
      w_alarm_nx = 1'b0;
      w_upd      = 1'b1;
    end else if (reload14) begin
      w_state_nx = ST_IDLE;
      w_tens_nx  = RELOAD14_TENS;
      w_ones_nx  = RELOAD14_ONES;
      w_alarm_nx = 1'b0;
      w_upd      = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE, ST_PAUSE: begin
          if (start) w_state_nx = ST_RUN;
        end
        ST_RUN: begin
          if (w_tick) begin
            w_upd = 1'b1;
            if (r_ones == 4'd0) begin
              w_ones_nx = 4'd9;
              w_tens_nx = r_tens - 4'd1;
            end else begin
              w_ones_nx = r_ones - 4'd1;
            end
            if (r_tens == 4'd0 && r_ones == 4'd1) begin
              w_state_nx     = ST_EXPIRED;
              w_alarm_nx     = 1'b1;
              w_alarm_cnt_nx = '0;
            end else if (pause) begin
              w_state_nx = ST_PAUSE;
            end
          end else if (pause) begin
            w_state_nx = ST_PAUSE;
          end
        end
        ST_EXPIRED: begin
          // The prescaler keeps running here only to time the alarm.
          if (w_tick && r_alarm) begin
            if (r_alarm_cnt == ALARM_LAST) begin
              w_alarm_nx = 1'b0;
            end else begin
              w_alarm_cnt_nx = r_alarm_cnt + ALARM_ONE;
            end
          end
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_tens      <= RELOAD24_TENS;
      r_ones      <= RELOAD24_ONES;
      r_alarm     <= 1'b0;
      r_alarm_cnt <= '0;
      r_upd       <= 1'b0;
      r_disp_en   <= 1'b1;
      r_running   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_tens      <= w_tens_nx;
      r_ones      <= w_ones_nx;
      r_alarm     <= w_alarm_nx;
      r_alarm_cnt <= w_alarm_cnt_nx;
      // Two-stage strobe: digits settle at edge N, strobe is high during cycle N+1.
      r_upd       <= w_upd;
      r_disp_en   <= r_upd;
      r_running   <= (w_state_nx == ST_RUN);
    end
  end

  assign tens    = r_tens;
  assign ones    = r_ones;
  assign alarm   = r_alarm;
  assign disp_en = r_disp_en;
  assign running = r_running;

endmodule

// File: tb/tb_shot_clock_ctrl.sv
// tb/tb_shot_clock_ctrl.sv - self-checking bench for shot_clock_ctrl against a seconds-level model
module tb_shot_clock_ctrl;

  localparam int TD = 4;
  localparam int AT = 2;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;
  localparam int M_DONE = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       reload = 1'b0;
  logic       reload14 = 1'b0;
  logic [3:0] tens, ones;
  logic       disp_en, running, alarm;

  int tests = 0;
  int fails = 0;

  // Behavioural model: remaining seconds as an integer, phase within the second.
  int m_secs, m_phase, m_mode, m_alarm, m_alarm_ticks, m_changed, m_disp, m_run;

  shot_clock_ctrl #(.TICK_DIV(TD), .ALARM_TICKS(AT)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause),
    .reload(reload), .reload14(reload14),
    .tens(tens), .ones(ones), .disp_en(disp_en), .running(running), .alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit s, input bit p, input bit r, input bit r14, input bit rs);
    bit counting, tick;
    if (rs) begin
      m_secs = 24; m_phase = 0; m_mode = M_IDLE; m_alarm = 0; m_alarm_ticks = 0;
      m_changed = 0; m_disp = 1; m_run = 0;
      return;
    end
    m_disp = m_changed;
    m_changed = 0;
    counting = (m_mode == M_RUN) || (m_mode == M_DONE);
    tick = counting && (m_phase == TD - 1);
    if (r || r14) begin
      m_secs = r ? 24 : 14;
      m_phase = 0; m_alarm = 0; m_mode = M_IDLE; m_changed = 1;
    end else begin
      if (counting) m_phase = (m_phase + 1) % TD;
      if (m_mode == M_RUN) begin
        if (tick) begin
          m_secs = m_secs - 1;
          m_changed = 1;
          if (m_secs == 0) begin
            m_mode = M_DONE; m_alarm = 1; m_alarm_ticks = 0;
          end
        end
        if (m_mode == M_RUN && p) m_mode = M_HOLD;
      end else if (m_mode == M_IDLE || m_mode == M_HOLD) begin
        if (s) m_mode = M_RUN;
      end else if (tick && m_alarm == 1) begin
        m_alarm_ticks++;
        if (m_alarm_ticks == AT) m_alarm = 0;
      end
    end
    m_run = (m_mode == M_RUN) ? 1 : 0;
  endtask

  task automatic step(input bit s = 0, input bit p = 0, input bit r = 0,
                      input bit r14 = 0, input bit rs = 0);
    start = s; pause = p; reload = r; reload14 = r14; reset = rs;
    @(posedge clk);
    model_edge(s, p, r, r14, rs);
    #1;
    start = 0; pause = 0; reload = 0; reload14 = 0; reset = 0;
    chk("tens",    int'(tens),    m_secs / 10);
    chk("ones",    int'(ones),    m_secs % 10);
    chk("disp_en", int'(disp_en), m_disp);
    chk("running", int'(running), m_run);
    chk("alarm",   int'(alarm),   m_alarm);
  endtask

  initial begin
    int n;
    m_secs = 24; m_phase = 0; m_mode = M_IDLE; m_alarm = 0;
    m_alarm_ticks = 0; m_changed = 0; m_disp = 1; m_run = 0;

    // Reset and release
    step(.rs(1)); step(.rs(1));
    chk("rst_tens", int'(tens), 2);
    chk("rst_ones", int'(ones), 4);
    chk("rst_disp_en", int'(disp_en), 1);
    step();
    chk("post_rst_disp_en", int'(disp_en), 0);

    // Start from IDLE, first decrement after a full TICK_DIV
    step(.s(1));
    for (int i = 0; i < TD; i++) step();
    chk("first_dec_ones", int'(ones), 3);
    step();
    chk("first_dec_strobe", int'(disp_en), 1);

    // Run down to expiry
    for (int i = 0; i < 200 && !(tens == 0 && ones == 0); i++) step();
    chk("expired_alarm", int'(alarm), 1);
    n = 1;
    for (int i = 0; i < 20 && alarm; i++) begin step(); if (alarm) n++; end
    chk("alarm_cycles", n, TD * AT);
    step(.s(1));
    chk("start_in_expired", int'(ones) + int'(tens), 0);

    // Both reloads together: 24 wins
    step(.r(1), .r14(1));
    chk("dual_reload_tens", int'(tens), 2);
    chk("dual_reload_ones", int'(ones), 4);

    // Pause mid-second, resume continues the partial second
    step(.s(1)); step(); step(.p(1));
    for (int i = 0; i < 10; i++) step();
    step(.s(1)); step();
    chk("resume_partial_hold", int'(ones), 4);
    step();
    chk("resume_partial_dec", int'(ones), 3);

    // reload14 coincident with the 01->00 tick
    step(.r14(1)); step(.s(1));
    for (int i = 0; i < 13 * TD; i++) step();
    chk("at_01", int'(ones), 1);
    for (int i = 0; i < TD - 1; i++) step();
    step(.r14(1));
    chk("r14_vs_tick_tens", int'(tens), 1);
    chk("r14_vs_tick_alarm", int'(alarm), 0);

    // Mid-count reset with a partial prescaler
    step(.r(1)); step(.s(1));
    for (int i = 0; i < 11 * TD + 2; i++) step();
    chk("at_13", int'(tens) * 10 + int'(ones), 13);
    step(.rs(1));
    chk("mid_reset_ones", int'(ones), 4);
    step(.s(1));
    for (int i = 0; i < TD - 1; i++) step();
    chk("after_reset_no_early_dec", int'(ones), 4);
    step();
    chk("after_reset_full_second", int'(ones), 3);

    // Randomized commands
    for (int i = 0; i < 3000; i++) begin
      int v;
      v = int'($urandom_range(0, 999));
      step(.s(v < 60), .p(v >= 60 && v < 100),
           .r(v >= 100 && v < 104), .r14(v >= 102 && v < 108),
           .rs(v >= 998));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
